// File: rtl/regwrite_trace.sv
// Register-write trace capture: snoops the regfile write port, timestamps qualifying
// writes and buffers them in a first-word-fall-through FIFO drained via valid/ready.
module regwrite_trace #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int CYCLE_WIDTH    = 16,
  parameter int MAX_CYCLES     = 255
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      match_en,
  input  logic [REG_ADDR_WIDTH-1:0] match_reg,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [CYCLE_WIDTH-1:0]    rd_cycle,
  output logic [REG_ADDR_WIDTH-1:0] rd_reg,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic [CYCLE_WIDTH-1:0]    dropped,
  output logic                      running,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_next;
  logic [CYCLE_WIDTH-1:0]    cyc;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CYCLE_WIDTH-1:0]    mem_cycle [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] mem_reg   [DEPTH];
  logic [DATA_WIDTH-1:0]     mem_data  [DEPTH];
  logic                      last, qualify, full, pop, push;

  always_comb begin
    last       = (state == RUN) && (cyc == CYCLE_WIDTH'(MAX_CYCLES - 1));
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = RUN;
    running = (state == RUN);
    done    = (state == DONE);
  end

  always_comb begin
    qualify  = (state == RUN) && wr_en && (wr_reg != '0) &&
               (!match_en || (wr_reg == match_reg));
    full     = (count == CW'(DEPTH));
    rd_valid = (count != '0);
    pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push     = qualify && (!full || pop);
    rd_cycle = rd_valid ? mem_cycle[rd_ptr] : '0;
    rd_reg   = rd_valid ? mem_reg[rd_ptr]   : '0;
    rd_data  = rd_valid ? mem_data[rd_ptr]  : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cyc     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        cyc     <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        dropped <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (qualify && !push && (dropped != '1)) dropped <= dropped + 1'b1;
        if ((state == RUN) && !last) cyc <= cyc + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !start) begin
      mem_cycle[wr_ptr] <= cyc;
      mem_reg[wr_ptr]   <= wr_reg;
      mem_data[wr_ptr]  <= wr_data;
    end
  end

endmodule

// File: tb/tb_regwrite_trace.sv
// Bench for regwrite_trace: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the capture rules.
module tb_regwrite_trace;

  localparam int DW    = 16;
  localparam int RW    = 5;
  localparam int DEP   = 4;
  localparam int CYW   = 8;
  localparam int MAXC  = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, wr_en, match_en, rd_ready;
  logic [RW-1:0] wr_reg, match_reg;
  logic [DW-1:0] wr_data;
  logic          rd_valid, running, done;
  logic [CYW-1:0] rd_cycle, dropped;
  logic [RW-1:0] rd_reg;
  logic [DW-1:0] rd_data;
  logic [$clog2(DEP):0] count;

  regwrite_trace #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DEPTH(DEP),
    .CYCLE_WIDTH(CYW), .MAX_CYCLES(MAXC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .match_en(match_en), .match_reg(match_reg),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_cycle(rd_cycle), .rd_reg(rd_reg), .rd_data(rd_data),
    .count(count), .dropped(dropped), .running(running), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {int cyc; int rg; int dt;} ent_t;
  ent_t q[$];
  int   m_cyc, m_drop;
  bit   m_run, m_done;
  int   total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_drop = 0; m_run = 0; m_done = 0;
  endtask

  // Applies one clock edge of the capture rules to the model.
  task automatic model_step();
    bit qual;
    if (start) begin
      q.delete();
      m_cyc = 0; m_drop = 0; m_run = 1; m_done = 0;
      return;
    end
    qual = m_run && wr_en && (wr_reg != 0) && (!match_en || wr_reg == match_reg);
    if (q.size() != 0 && rd_ready) void'(q.pop_front());
    if (qual) begin
      if (q.size() < DEP) q.push_back('{m_cyc, int'(wr_reg), int'(wr_data)});
      else if (m_drop < (1 << CYW) - 1) m_drop++;
    end
    if (m_run) begin
      if (m_cyc == MAXC - 1) begin
        m_run = 0; m_done = 1;
      end else m_cyc++;
    end
  endtask

  task automatic compare();
    check_eq("rd_valid", rd_valid, q.size() != 0);
    check_eq("count", count, q.size());
    check_eq("running", running, m_run);
    check_eq("done", done, m_done);
    check_eq("dropped", dropped, m_drop);
    if (q.size() != 0) begin
      check_eq("rd_cycle", rd_cycle, q[0].cyc);
      check_eq("rd_reg", rd_reg, q[0].rg);
      check_eq("rd_data", rd_data, q[0].dt);
    end else begin
      check_eq("rd_cycle_zero", rd_cycle, 0);
      check_eq("rd_reg_zero", rd_reg, 0);
      check_eq("rd_data_zero", rd_data, 0);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic drive(input bit st, input bit en, input int rg, input int dt,
                       input bit men, input int mrg, input bit rdy);
    start = st; wr_en = en; wr_reg = rg[RW-1:0]; wr_data = dt[DW-1:0];
    match_en = men; match_reg = mrg[RW-1:0]; rd_ready = rdy;
    cycle();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; wr_en = 0; wr_reg = '0; wr_data = '0;
    match_en = 0; match_reg = '0; rd_ready = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    compare();
    reset_n = 1'b1;
    idle(1, 1);

    // Single write captured, register 0 ignored.
    drive(1, 0, 0, 0, 0, 0, 1);
    idle(3, 1);
    drive(0, 1, 5, 7, 0, 0, 1);
    drive(0, 1, 0, 9, 0, 0, 1);
    idle(6, 1);

    // Continuous writes across a whole window; nothing after it closes.
    drive(1, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < MAXC + 4; c++) drive(0, 1, 1, c, 0, 0, 1);
    idle(2, 1);

    // Overflow, then a push coinciding with a pop while full.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 2 + i, 100 + i, 0, 0, 0);
    drive(0, 1, 9, 200, 0, 0, 1);
    idle(6, 1);

    // Register filter, including match_reg = 0.
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 2, 11, 1, 3, 1);
    drive(0, 1, 3, 12, 1, 3, 1);
    drive(0, 1, 4, 13, 1, 3, 1);
    drive(0, 1, 3, 14, 1, 3, 1);
    drive(0, 1, 0, 15, 1, 0, 1);
    idle(4, 1);

    // Asynchronous reset mid-run with entries pending.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 6, 30 + i, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare();
    @(negedge clock);
    reset_n = 1'b1;
    idle(2, 1);

    // start while DONE with a non-empty FIFO.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 40, 0, 0, 0);
    drive(0, 1, 8, 41, 0, 0, 0);
    idle(MAXC, 0);
    drive(1, 1, 7, 42, 0, 0, 0);
    drive(0, 1, 7, 43, 0, 0, 1);
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
            $urandom_range(0, 7), $urandom_range(0, 65535),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
